// File: rtl/dsp_addsub_simd_pipe.sv
// Packed SIMD add/subtract over a 48-bit word with optional lane saturation.
// Pipelined, ce-qualified, with per-lane overflow and sticky overflow flags.
module dsp_addsub_simd_pipe #(
    parameter int LANES    = 4,
    parameter int LATENCY  = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             op,
    input  logic [47:0]      a,
    input  logic [47:0]      b,
    input  logic             clr_sticky,
    output logic             out_valid,
    output logic [47:0]      ap_return,
    output logic [LANES-1:0] ovf,
    output logic [LANES-1:0] ovf_sticky
);

    localparam int LANE_W = 48 / LANES;

    logic [LANES-1:0][LANE_W:0] exact;
    logic [47:0]                res_d;
    logic [LANES-1:0]           lane_ovf_d;

    logic [LATENCY-1:0]             vld_q, vld_d;
    logic [LATENCY-1:0][47:0]       dat_q, dat_d;
    logic [LATENCY-1:0][LANES-1:0]  flg_q, flg_d;
    logic [LANES-1:0]               sticky_q, sticky_d;

    // Iterate by bit position: lane 0 sits in the MSBs, and the flag
    // vectors are packed the same way, so position p serves lane LANES-1-p.
    always_comb begin
        exact      = '0;
        res_d      = '0;
        lane_ovf_d = '0;
        for (int p = 0; p < LANES; p++) begin
            if (op) begin
                exact[p] = {a[p*LANE_W+LANE_W-1], a[p*LANE_W +: LANE_W]}
                         - {b[p*LANE_W+LANE_W-1], b[p*LANE_W +: LANE_W]};
            end else begin
                exact[p] = {a[p*LANE_W+LANE_W-1], a[p*LANE_W +: LANE_W]}
                         + {b[p*LANE_W+LANE_W-1], b[p*LANE_W +: LANE_W]};
            end
            lane_ovf_d[p] = exact[p][LANE_W] ^ exact[p][LANE_W-1];
            if ((SATURATE != 0) && lane_ovf_d[p]) begin
                if (exact[p][LANE_W]) begin
                    res_d[p*LANE_W +: LANE_W] = {1'b1, {(LANE_W-1){1'b0}}};
                end else begin
                    res_d[p*LANE_W +: LANE_W] = {1'b0, {(LANE_W-1){1'b1}}};
                end
            end else begin
                res_d[p*LANE_W +: LANE_W] = exact[p][LANE_W-1:0];
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        flg_d    = flg_q;
        sticky_d = sticky_q;
        if (ce) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                dat_d[0] = res_d;
                flg_d[0] = lane_ovf_d;
            end
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    dat_d[s] = dat_q[s-1];
                    flg_d[s] = flg_q[s-1];
                end
            end
            // Setting from the presented result wins over a coincident clear.
            sticky_d = (clr_sticky ? '0 : sticky_q)
                     | (vld_q[LATENCY-1] ? flg_q[LATENCY-1] : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q    <= '0;
            dat_q    <= '0;
            flg_q    <= '0;
            sticky_q <= '0;
        end else begin
            vld_q    <= vld_d;
            dat_q    <= dat_d;
            flg_q    <= flg_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = vld_q[LATENCY-1];
    assign ap_return  = dat_q[LATENCY-1];
    assign ovf        = flg_q[LATENCY-1];
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_dsp_addsub_simd_pipe.sv
// Bench for dsp_addsub_simd_pipe: three configurations share one stimulus
// stream and are compared every cycle against a lane-arithmetic model.
module tb_dsp_addsub_simd_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic        clr_sticky = 1'b0;
    logic [47:0] a = '0;
    logic [47:0] b = '0;

    logic        m_ov, s_ov, t_ov;
    logic [47:0] m_ap, s_ap, t_ap;
    logic [3:0]  m_of, m_st, s_of, s_st;
    logic [1:0]  t_of, t_st;

    dsp_addsub_simd_pipe #(.LANES(4), .LATENCY(2), .SATURATE(0)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .clr_sticky(clr_sticky), .out_valid(m_ov),
        .ap_return(m_ap), .ovf(m_of), .ovf_sticky(m_st));

    dsp_addsub_simd_pipe #(.LANES(4), .LATENCY(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .clr_sticky(clr_sticky), .out_valid(s_ov),
        .ap_return(s_ap), .ovf(s_of), .ovf_sticky(s_st));

    dsp_addsub_simd_pipe #(.LANES(2), .LATENCY(1), .SATURATE(0)) u_l2 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .clr_sticky(clr_sticky), .out_valid(t_ov),
        .ap_return(t_ap), .ovf(t_of), .ovf_sticky(t_st));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int cl[3]   = '{4, 4, 2};
    int clat[3] = '{2, 2, 1};
    bit csat[3] = '{1'b0, 1'b1, 1'b0};

    bit          acc_v  [0:1023];
    bit          acc_op [0:1023];
    logic [47:0] acc_a  [0:1023];
    logic [47:0] acc_b  [0:1023];
    logic [3:0]  st_m   [3];
    int          n = 0;
    bit          model_on = 1'b0;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Exact signed lane arithmetic; flags packed with lane 0 in the MSB.
    function automatic void calc(input int lanes, input bit sat, input bit o,
                                 input logic [47:0] x, input logic [47:0] y,
                                 output logic [47:0] r, output logic [3:0] f);
        int w, sh;
        longint m, hi, lo, xa, yb, e;
        w  = 48 / lanes;
        m  = longint'(1) << w;
        hi = (m >> 1) - 1;
        lo = -(m >> 1);
        r  = '0;
        f  = '0;
        for (int i = 0; i < lanes; i++) begin
            sh = 48 - (i + 1) * w;
            xa = longint'(x >> sh) & (m - 1);
            yb = longint'(y >> sh) & (m - 1);
            if (xa > hi) xa -= m;
            if (yb > hi) yb -= m;
            e = o ? xa - yb : xa + yb;
            if (e > hi || e < lo) begin
                f[lanes-1-i] = 1'b1;
                if (sat) e = (e > hi) ? hi : lo;
            end
            r |= 48'(e & (m - 1)) << sh;
        end
    endfunction

    // What configuration c must present after n ce edges since reset.
    function automatic void expect_out(input int c, output bit v,
                                       output logic [47:0] d, output logic [3:0] f);
        int idx, j;
        idx = n - clat[c] + 1;
        v = 1'b0;
        d = '0;
        f = '0;
        if (idx >= 1) begin
            v = acc_v[idx];
            j = idx;
            while (j >= 1 && !acc_v[j]) j--;
            if (j >= 1) calc(cl[c], csat[c], acc_op[j], acc_a[j], acc_b[j], d, f);
        end
    endfunction

    always @(posedge clk) begin : model
        bit v;
        logic [47:0] d;
        logic [3:0] f;
        if (rst && ce && m_ov) pulses++;
        if (!rst) begin
            n = 0;
            for (int c = 0; c < 3; c++) st_m[c] = '0;
            model_on = 1'b1;
        end else if (ce) begin
            for (int c = 0; c < 3; c++) begin
                expect_out(c, v, d, f);
                st_m[c] = (clr_sticky ? 4'b0 : st_m[c]) | (v ? f : 4'b0);
            end
            if (n < 1023) n++;
            acc_v[n]  = in_valid;
            acc_op[n] = op;
            acc_a[n]  = a;
            acc_b[n]  = b;
        end
    end

    always @(negedge clk) begin : compare
        bit v;
        logic [47:0] d;
        logic [3:0] f;
        logic av;
        logic [47:0] ad;
        logic [3:0] af, as;
        if (model_on) begin
            for (int c = 0; c < 3; c++) begin
                expect_out(c, v, d, f);
                case (c)
                    0: begin av = m_ov; ad = m_ap; af = m_of; as = m_st; end
                    1: begin av = s_ov; ad = s_ap; af = s_of; as = s_st; end
                    default: begin
                        av = t_ov; ad = t_ap; af = {2'b0, t_of}; as = {2'b0, t_st};
                    end
                endcase
                chk($sformatf("cfg%0d out_valid", c), 48'(av), 48'(v));
                chk($sformatf("cfg%0d ap_return", c), ad, d);
                chk($sformatf("cfg%0d ovf", c), 48'(af), 48'(f));
                chk($sformatf("cfg%0d ovf_sticky", c), 48'(as), 48'(st_m[c]));
            end
        end
    end

    task automatic cyc(input bit v, input bit o, input logic [47:0] x,
                       input logic [47:0] y, input bit e = 1'b1, input bit c = 1'b0);
        in_valid   = v;
        op         = o;
        a          = x;
        b          = y;
        ce         = e;
        clr_sticky = c;
        @(negedge clk);
    endtask

    localparam logic [47:0] V1A = 48'h7FF_001_800_123;
    localparam logic [47:0] V1B = 48'h001_FFF_FFF_001;

    logic [47:0] ta[10] = '{48'h123_456_789_ABC, 48'h7FF_7FF_7FF_7FF,
                            48'h800_800_800_800, 48'h000_000_000_000,
                            48'hFFF_001_400_C00, 48'h3FF_C01_7FE_801,
                            48'h555_AAA_555_AAA, 48'h800_7FF_001_FFF,
                            48'h0F0_F0F_00F_FF0, 48'h401_BFF_3FF_C00};
    logic [47:0] tb_[10] = '{48'h111_222_333_444, 48'h001_7FF_FFF_800,
                             48'h800_FFF_001_7FF, 48'h800_7FF_FFF_001,
                             48'h001_FFF_C00_400, 48'h401_3FF_002_7FF,
                             48'hAAA_555_AAA_555, 48'h001_FFF_800_7FF,
                             48'h00F_0F0_FF0_00F, 48'h3FF_401_C01_401};
    bit tv[10] = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    bit to[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    int p0;

    initial begin
        @(negedge clk);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        chk("reset out_valid", 48'(m_ov), 48'h0);
        chk("reset ap_return", m_ap, 48'h0);
        chk("reset sticky", 48'(m_st), 48'h0);
        rst = 1'b1;

        cyc(1, 0, V1A, V1B);
        chk("l2 early out_valid", 48'(t_ov), 48'h1);
        cyc(0, 0, '0, '0);
        chk("wrap ap_return", m_ap, 48'h800_000_7FF_124);
        chk("wrap ovf", 48'(m_of), 48'h0A);
        chk("wrap out_valid", 48'(m_ov), 48'h1);
        chk("sat ap_return", s_ap, 48'h7FF_000_800_124);
        cyc(0, 0, '0, '0);
        chk("sat sticky", 48'(s_st), 48'h0A);
        chk("pulse ends", 48'(m_ov), 48'h0);
        chk("held ap_return", m_ap, 48'h800_000_7FF_124);

        cyc(1, 1, 48'h000000_800000, 48'h000001_000001);
        chk("l2 sub ap_return", t_ap, 48'hFFFFFF_7FFFFF);
        chk("l2 sub ovf", 48'(t_of), 48'h1);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);

        p0 = pulses;
        cyc(1, 0, 48'h010_020_030_040, 48'h001_002_003_004);
        cyc(1, 1, 48'h7FF_800_000_100, 48'hFFF_001_001_200);
        cyc(1, 0, 48'hFFF_FFF_FFF_FFF, 48'hFFF_FFF_FFF_FFF, 1'b0);
        cyc(1, 1, 48'h123_123_123_123, 48'h321_321_321_321, 1'b0, 1'b1);
        cyc(1, 0, 48'h400_400_C00_C00, 48'h400_C00_C00_400);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        chk("ce gap pulses", 48'(pulses - p0), 48'd3);

        for (int i = 0; i < 10; i++) cyc(tv[i], to[i], ta[i], tb_[i], 1'b1, i == 4);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0, 1'b0, 1'b1);

        cyc(0, 0, '0, '0, 1'b1, 1'b1);
        chk("clear sticky", 48'(m_st), 48'h0);
        cyc(1, 0, V1A, V1B);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0, 1'b1, 1'b1);
        chk("set beats clear", 48'(m_st), 48'h0A);
        cyc(0, 0, '0, '0, 1'b1, 1'b1);
        chk("clear alone", 48'(m_st), 48'h0);

        cyc(1, 0, V1A, V1B);
        cyc(1, 1, 48'h111_111_111_111, 48'h222_222_222_222);
        rst = 1'b0;
        cyc(1, 0, V1A, V1B, 1'b0);
        chk("mid reset ap_return", m_ap, 48'h0);
        chk("mid reset out_valid", 48'(m_ov), 48'h0);
        chk("mid reset l2 ap_return", t_ap, 48'h0);
        rst = 1'b1;
        p0 = pulses;
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        chk("no stale pulses", 48'(pulses - p0), 48'd0);
        cyc(1, 1, 48'h000_000_000_005, 48'h000_000_000_007);
        cyc(0, 0, '0, '0);
        chk("fresh out_valid", 48'(m_ov), 48'h1);
        chk("fresh ap_return", m_ap, 48'h000_000_000_FFE);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
